fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-cycle-derived MIPS datapath, sitting directly upstream of the instruction memory and directly downstream of decode/execute redirect logic. It owns the program counter, drives the word-aligned fetch address into the instruction memory, and captures the returned instruction into an IF/ID pipeline register. It also handles stall, branch/jump redirect with flush, and a fetch counter for bring-up.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (hazard unit).
- redirect  in  1  taken branch/jump/jr; load redirect_pc and flush IF/ID.
- redirect_pc  in  32  redirect target byte address.
- instr_rd  in  32  RD from instruction memory (combinational w.r.t. pc_a).
- pc_a  out  32  fetch address to instruction memory; equals current PC.
- if_instr  out  32  registered instruction for decode.
- if_pc  out  32  address the registered instruction was fetched from.
- if_pc4  out  32  if_pc + 4.
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- misaligned  out  1  sticky: a redirect target had bits [1:0] ≠ 0.
- fetch_count  out  32  number of instructions captured into IF/ID.

## Operation
- PC register: next value chosen by priority reset > redirect > stall > sequential.
  - reset: PC ← RESET_PC.
  - redirect: PC ← {redirect_pc[31:2], 2'b00}; if redirect_pc[1:0] ≠ 0, misaligned ← 1 (sticky until reset).
  - stall (no redirect): PC holds.
  - otherwise: PC ← PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- pc_a = PC, combinational; PC[1:0] is always 0.
- IF/ID register, same priority:
  - reset: if_instr ← 0 (NOP), if_pc ← 0, if_pc4 ← 0, if_valid ← 0.
  - redirect: flush — if_instr ← 0, if_valid ← 0; if_pc/if_pc4 ← 0.
  - stall: hold all IF/ID fields.
  - otherwise: if_instr ← instr_rd, if_pc ← PC, if_pc4 ← PC + 4, if_valid ← 1.
- fetch_count: reset → 0; increments by 1 on each edge where IF/ID loads (not reset, not redirect, not stall); wraps at 2^32.
- Redirect during stall: redirect wins; PC loads target, IF/ID flushes.
- Addresses beyond the memory depth are not trapped; the instruction memory aliases on its index bits.

## Timing
- All state updates on rising clk; no asynchronous paths.
- Reset values: pc_a = RESET_PC, if_instr = 0, if_pc = 0, if_pc4 = 0, if_valid = 0, misaligned = 0, fetch_count = 0.
- Fetch latency: instruction at address X appears on if_instr one edge after pc_a = X with stall = 0, redirect = 0.
- Redirect penalty: edge N samples redirect. if_valid = 0 after edge N. Target instruction is in IF/ID after edge N+1 if no stall.
- Stall held k cycles: pc_a and IF/ID frozen for exactly k edges; resumes on the first edge with stall = 0.
- Reset asserted mid-stream: the next edge overrides stall/redirect; the first post-reset capture is from RESET_PC.

## Structure
- Shared package: XLEN = 32, NOP = 32'h0, default RESET_PC, PC_STEP = 4.
- One natural sub-module: if_id_reg, holding instr, pc, pc4, and valid, with load/flush/hold controls. fetch_stage keeps the PC, next-PC mux, misaligned flag, and counter.

## Test plan
- Reset then free-run with memory word i = 32'h1000_0000 + i: if_instr sequence is 1000_0000, 1000_0001, …; if_pc = 0, 4, 8; fetch_count = 3 after 3 captures.
- stall high 2 cycles while pc_a = 8: pc_a stays 8 and IF/ID stays at pc 4 for 2 edges; next edge captures pc 8; fetch_count does not advance during the stall.
- redirect = 1, redirect_pc = 0x40 at pc_a = 0x10: next pc_a = 0x40 and if_valid = 0; following edge gives if_pc = 0x40, if_pc4 = 0x44, if_valid = 1.
- redirect with redirect_pc = 0x22: pc_a = 0x20 and misaligned = 1, and it stays 1 through later redirects until reset.
- redirect and stall asserted together: redirect behaviour (same as test 3); then reset mid-run: all outputs return to their reset values on that edge.
- Set RESET_PC = 32'hFFFF_FFFC and run 2 cycles: pc_a goes FFFF_FFFC → 0 → 4; if_pc4 of the first capture is 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths and constants for the instruction-fetch stage
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, flush and hold
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_pc4,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= NOP;
      pc    <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= d_instr;
      pc    <= d_pc;
      pc4   <= d_pc4;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, redirect/stall handling and IF/ID capture
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_P = RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] instr_rd,
  output logic [XLEN-1:0] pc_a,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic            if_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] fetch_count
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  assign pc_next_seq = pc + PC_STEP;
  assign pc_a = pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC_P;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc         <= {redirect_pc[XLEN-1:2], 2'b00};
      misaligned <= misaligned | (|redirect_pc[1:0]);
    end else if (!stall) begin
      pc          <= pc_next_seq;
      fetch_count <= fetch_count + 32'd1;
    end
  end
  if_id_reg u_if_id (
    .clk    (clk),
    .rst    (reset),
    .load   (!stall),
    .flush  (redirect),
    .d_instr(instr_rd),
    .d_pc   (pc),
    .d_pc4  (pc_next_seq),
    .instr  (if_instr),
    .pc     (if_pc),
    .pc4    (if_pc4),
    .valid  (if_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] rd0, rd1, pa0, pa1, in0, in1, ip0, ip1, i40, i41, cn0, cn1;
  logic v0, v1, m0, m1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // memory model: word at byte address A holds 32'h1000_0000 + A/4
  assign rd0 = 32'h1000_0000 + {2'b00, pa0[31:2]};
  assign rd1 = 32'h1000_0000 + {2'b00, pa1[31:2]};

  fetch_stage dut0 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_rd(rd0), .pc_a(pa0), .if_instr(in0),
    .if_pc(ip0), .if_pc4(i40), .if_valid(v0), .misaligned(m0), .fetch_count(cn0)
  );
  fetch_stage #(.RESET_PC_P(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_rd(rd1), .pc_a(pa1), .if_instr(in1),
    .if_pc(ip1), .if_pc4(i41), .if_valid(v1), .misaligned(m1), .fetch_count(cn1)
  );

  typedef struct {
    logic rst, stl, rdr, sel;
    logic [31:0] rpc, pc_a, instr, pc, pc4;
    logic v, mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic add(input logic rst, stl, rdr, sel, input logic [31:0] rpc, pc_a,
                     instr, pc, pc4, input logic v, mis, input logic [31:0] cnt);
    vec_t t;
    t.rst = rst; t.stl = stl; t.rdr = rdr; t.sel = sel; t.rpc = rpc;
    t.pc_a = pc_a; t.instr = instr; t.pc = pc; t.pc4 = pc4;
    t.v = v; t.mis = mis; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input int idx, input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s got %h expected %h", idx, name, act, exp);
    end
  endtask

  initial begin
    //   rst stl rdr sel rpc        pc_a          instr         pc            pc4           v  mis cnt
    add(1, 0, 0, 0, 32'h0,   32'h0,   32'h0,         32'h0,   32'h0,   0, 0, 0);
    add(0, 0, 0, 0, 32'h0,   32'h4,   32'h1000_0000, 32'h0,   32'h4,   1, 0, 1);
    add(0, 0, 0, 0, 32'h0,   32'h8,   32'h1000_0001, 32'h4,   32'h8,   1, 0, 2);
    add(0, 1, 0, 0, 32'h0,   32'h8,   32'h1000_0001, 32'h4,   32'h8,   1, 0, 2);
    add(0, 1, 0, 0, 32'h0,   32'h8,   32'h1000_0001, 32'h4,   32'h8,   1, 0, 2);
    add(0, 0, 0, 0, 32'h0,   32'hC,   32'h1000_0002, 32'h8,   32'hC,   1, 0, 3);
    add(0, 0, 0, 0, 32'h0,   32'h10,  32'h1000_0003, 32'hC,   32'h10,  1, 0, 4);
    add(0, 0, 1, 0, 32'h40,  32'h40,  32'h0,         32'h0,   32'h0,   0, 0, 4);
    add(0, 0, 0, 0, 32'h0,   32'h44,  32'h1000_0010, 32'h40,  32'h44,  1, 0, 5);
    add(0, 0, 1, 0, 32'h22,  32'h20,  32'h0,         32'h0,   32'h0,   0, 1, 5);
    add(0, 0, 0, 0, 32'h0,   32'h24,  32'h1000_0008, 32'h20,  32'h24,  1, 1, 6);
    add(0, 1, 1, 0, 32'h80,  32'h80,  32'h0,         32'h0,   32'h0,   0, 1, 6);
    add(0, 0, 0, 0, 32'h0,   32'h84,  32'h1000_0020, 32'h80,  32'h84,  1, 1, 7);
    add(0, 1, 1, 0, 32'h100, 32'h100, 32'h0,         32'h0,   32'h0,   0, 1, 7);
    add(0, 1, 0, 0, 32'h0,   32'h100, 32'h0,         32'h0,   32'h0,   0, 1, 7);
    add(0, 0, 0, 0, 32'h0,   32'h104, 32'h1000_0040, 32'h100, 32'h104, 1, 1, 8);
    add(1, 1, 1, 0, 32'h44,  32'h0,   32'h0,         32'h0,   32'h0,   0, 0, 0);
    add(0, 0, 0, 0, 32'h0,   32'h4,   32'h1000_0000, 32'h0,   32'h4,   1, 0, 1);
    add(1, 0, 0, 1, 32'h0,   32'hFFFF_FFFC, 32'h0,   32'h0,   32'h0,   0, 0, 0);
    add(0, 0, 0, 1, 32'h0,   32'h0,   32'h4FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1, 0, 1);
    add(0, 0, 0, 1, 32'h0,   32'h4,   32'h1000_0000, 32'h0,   32'h4,   1, 0, 2);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(negedge clk);
      reset = vecs[i].rst; stall = vecs[i].stl;
      redirect = vecs[i].rdr; redirect_pc = vecs[i].rpc;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL vec%0d scoreboard empty got 0 expected 1", i);
      end else begin
        e = sb.pop_front();
        chk(i, "pc_a",        e.sel ? pa1 : pa0, e.pc_a);
        chk(i, "if_instr",    e.sel ? in1 : in0, e.instr);
        chk(i, "if_pc",       e.sel ? ip1 : ip0, e.pc);
        chk(i, "if_pc4",      e.sel ? i41 : i40, e.pc4);
        chk(i, "if_valid",    {31'b0, e.sel ? v1 : v0}, {31'b0, e.v});
        chk(i, "misaligned",  {31'b0, e.sel ? m1 : m0}, {31'b0, e.mis});
        chk(i, "fetch_count", e.sel ? cn1 : cn0, e.cnt);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
